// File: rtl/uart_decimal_parser_pkg.sv
// Shared UART ASCII definitions: byte constants and parser state encoding,
// common to the decimal parser and the matching decimal transmitter.
package uart_decimal_parser_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } parserState_e;

  function automatic logic isTerminator(input logic [7:0] rxByte);
    return (rxByte == ASCII_CR) || (rxByte == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_decimal_parser_classifier.sv
// Combinational byte classifier: splits a received byte into digit,
// line-terminator or neither, and extracts the digit's binary value.
module ascii_digit_classifier
  import uart_decimal_parser_pkg::*;
(
  input  logic [7:0] rxByte,
  output logic       isDigit,
  output logic       isTerm,
  output logic [3:0] digit
);

  assign isDigit = (rxByte >= ASCII_ZERO) && (rxByte <= ASCII_NINE);
  assign isTerm  = isTerminator(rxByte);
  // Low nibble of '0'..'9' is the digit value itself.
  assign digit   = rxByte[3:0];

endmodule

// File: rtl/uart_decimal_parser.sv
// Parses CR/LF-terminated ASCII decimal frames from a UART receiver into a
// binary value, rejecting frames that are malformed or out of range.
module uart_decimal_parser
  import uart_decimal_parser_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 16,
  parameter int MAX_VALUE       = 9999,
  parameter int MAX_DIGITS      = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [7:0]                 RxData,
  input  logic                       RxReady,
  output logic                       RxAck,
  output logic [INPUT_BIT_WIDTH-1:0] Value,
  output logic                       ValueValid,
  output logic                       ParseError,
  output logic                       Busy
);

  localparam int WIDE_WIDTH  = INPUT_BIT_WIDTH + 4;
  localparam int COUNT_WIDTH = $clog2(MAX_DIGITS + 1);

  parserState_e               state, stateNext;
  logic [INPUT_BIT_WIDTH-1:0] acc, accNext;
  logic [COUNT_WIDTH-1:0]     count, countNext;
  logic [INPUT_BIT_WIDTH-1:0] valueNext;
  logic                       ackNext, validNext, errNext;

  logic                       isDigit, isTerm;
  logic [3:0]                 digit;
  logic                       sample;
  logic [WIDE_WIDTH-1:0]      accWide;
  logic                       overflow;

  ascii_digit_classifier classifier (
    .rxByte  (RxData),
    .isDigit (isDigit),
    .isTerm  (isTerm),
    .digit   (digit)
  );

  // The ack cycle blocks sampling so a still-high RxReady is not re-consumed.
  assign sample   = RxReady && !RxAck;
  assign accWide  = WIDE_WIDTH'(acc) * WIDE_WIDTH'(10) + WIDE_WIDTH'(digit);
  assign overflow = (count == COUNT_WIDTH'(MAX_DIGITS)) ||
                    (accWide > WIDE_WIDTH'(MAX_VALUE));
  assign Busy     = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    stateNext = state;
    accNext   = acc;
    countNext = count;
    valueNext = Value;
    ackNext   = sample;
    validNext = 1'b0;
    errNext   = 1'b0;

    if (sample) begin
      unique case (state)
        IDLE: begin
          if (isDigit) begin
            accNext   = INPUT_BIT_WIDTH'(digit);
            countNext = COUNT_WIDTH'(1);
            stateNext = ACCUM;
          end else if (!isTerm) begin
            errNext   = 1'b1;
            stateNext = DISCARD;
          end
        end
        ACCUM: begin
          if (isDigit && !overflow) begin
            accNext   = accWide[INPUT_BIT_WIDTH-1:0];
            countNext = count + COUNT_WIDTH'(1);
          end else begin
            // Frame ends here either way; clear the partial number.
            accNext   = '0;
            countNext = '0;
            if (isTerm) begin
              valueNext = acc;
              validNext = 1'b1;
              stateNext = IDLE;
            end else begin
              errNext   = 1'b1;
              stateNext = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (isTerm) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Outputs are registered together with the state, so ValueValid and
  // ParseError land in the same cycle as the RxAck of their byte.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      Value      <= '0;
      RxAck      <= 1'b0;
      ValueValid <= 1'b0;
      ParseError <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values sampled at the same edge, independent of statement order.
      state      <= stateNext;
      acc        <= accNext;
      count      <= countNext;
      Value      <= valueNext;
      RxAck      <= ackNext;
      ValueValid <= validNext;
      ParseError <= errNext;
    end
  end

endmodule

// File: tb/tb_uart_decimal_parser.sv
// Self-checking bench: two parser instances (default and 8-bit/255/3-digit)
// see the same byte stream and are compared against a string-level model.
module tb_uart_decimal_parser;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  RxData;
  logic        RxReady;

  logic        rxAck0, valueValid0, parseError0, busy0;
  logic [15:0] value0;
  logic        rxAck1, valueValid1, parseError1, busy1;
  logic [7:0]  value1;

  int testsRun  = 0;
  int failCount = 0;
  int ackCount  = 0;
  int validCount = 0;
  int errCount  = 0;

  // Reference model state, one slot per DUT instance.
  string frameStr[2];
  bit    rejected[2];
  int    mValue[2];
  bit    expValid[2];
  bit    expErr[2];
  int    maxVal[2] = '{9999, 255};
  int    maxDig[2] = '{4, 3};
  bit    lastB2b = 1'b0;

  always #5 Clk = ~Clk;

  uart_decimal_parser dut0 (
    .Clk        (Clk),
    .Reset      (Reset),
    .RxData     (RxData),
    .RxReady    (RxReady),
    .RxAck      (rxAck0),
    .Value      (value0),
    .ValueValid (valueValid0),
    .ParseError (parseError0),
    .Busy       (busy0)
  );

  uart_decimal_parser #(
    .INPUT_BIT_WIDTH (8),
    .MAX_VALUE       (255),
    .MAX_DIGITS      (3)
  ) dut1 (
    .Clk        (Clk),
    .Reset      (Reset),
    .RxData     (RxData),
    .RxReady    (RxReady),
    .RxAck      (rxAck1),
    .Value      (value1),
    .ValueValid (valueValid1),
    .ParseError (parseError1),
    .Busy       (busy1)
  );

  always @(posedge Clk) begin
    if (rxAck0 === 1'b1) ackCount++;
    if (valueValid0 === 1'b1) validCount++;
    if (parseError0 === 1'b1) errCount++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      frameStr[k] = "";
      rejected[k] = 1'b0;
      mValue[k]   = 0;
    end
  endtask

  // Frame rules stated on the text of the frame: a frame is good while it
  // holds at most maxDig digits whose decimal value is at most maxVal.
  task automatic modelByte(input logic [7:0] b);
    bit isDig, isTrm;
    isDig = (b >= "0") && (b <= "9");
    isTrm = (b == 8'h0D) || (b == 8'h0A);
    for (int k = 0; k < 2; k++) begin
      expValid[k] = 1'b0;
      expErr[k]   = 1'b0;
      if (rejected[k]) begin
        if (isTrm) rejected[k] = 1'b0;
      end else if (isTrm) begin
        if (frameStr[k].len() > 0) begin
          mValue[k]   = frameStr[k].atoi();
          expValid[k] = 1'b1;
        end
        frameStr[k] = "";
      end else if (isDig) begin
        frameStr[k] = $sformatf("%s%c", frameStr[k], b);
        if (frameStr[k].len() > maxDig[k] || frameStr[k].atoi() > maxVal[k]) begin
          expErr[k]   = 1'b1;
          rejected[k] = 1'b1;
          frameStr[k] = "";
        end
      end else begin
        expErr[k]   = 1'b1;
        rejected[k] = 1'b1;
        frameStr[k] = "";
      end
    end
  endtask

  function automatic bit modelBusy(input int k);
    return rejected[k] || (frameStr[k].len() > 0);
  endfunction

  // Presents one byte and checks the ack cycle. Unless back-to-back, RxReady
  // stays high through the cycle after the ack, then drops for one cycle.
  task automatic sendByte(input logic [7:0] b, input bit b2b);
    int waitCycles;
    int expLat;
    expLat  = lastB2b ? 2 : 1;
    lastB2b = b2b;
    RxData  = b;
    RxReady = 1'b1;
    modelByte(b);
    waitCycles = 0;
    do begin
      @(negedge Clk);
      waitCycles++;
    end while (rxAck0 !== 1'b1 && waitCycles < 8);
    check("ack latency", waitCycles, expLat);
    check("ack0", rxAck0, 1);
    check("ack1", rxAck1, 1);
    check("valid0", valueValid0, expValid[0]);
    check("valid1", valueValid1, expValid[1]);
    check("err0", parseError0, expErr[0]);
    check("err1", parseError1, expErr[1]);
    check("value0", value0, mValue[0]);
    check("value1", value1, mValue[1]);
    check("busy0", busy0, modelBusy(0));
    check("busy1", busy1, modelBusy(1));
    if (!b2b) begin
      @(negedge Clk);
      check("no double ack", rxAck0, 0);
      check("pulse width", valueValid0 | parseError0, 0);
      RxReady = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i], 1'b0);
  endtask

  initial begin
    int acks0, valids0, errs0;
    logic [7:0] b;
    int r;
    Reset   = 1'b1;
    RxReady = 1'b0;
    RxData  = 8'h00;
    modelReset();
    repeat (2) @(negedge Clk);
    check("reset value0", value0, 0);
    check("reset value1", value1, 0);
    check("reset ack", rxAck0 | rxAck1, 0);
    check("reset pulses", valueValid0 | parseError0 | valueValid1 | parseError1, 0);
    check("reset busy", busy0 | busy1, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // "123"CR with 3-cycle byte slots: four acks, one ValueValid.
    acks0 = ackCount; valids0 = validCount;
    sendStr("123\r");
    check("req030 acks", ackCount - acks0, 4);
    check("req030 valids", validCount - valids0, 1);
    check("req030 value", value0, 123);

    // "9999"CR LF: one value; LF is silent. Small instance rejects 999.
    valids0 = validCount;
    sendStr("9999\r\n");
    check("req031 valids", validCount - valids0, 1);
    check("req031 value", value0, 9999);

    // Leading zeros count toward the digit limit.
    sendStr("0042\r");
    check("zeros ok", value0, 42);
    sendStr("00042\r");
    check("zeros reject", value0, 42);

    // Too many digits, then a recovery frame; "256" overflows the 255 instance.
    valids0 = validCount;
    sendStr("10000\r");
    check("req032 no valid", validCount - valids0, 0);
    check("req032 value held", value0, 42);
    sendStr("7\r");
    check("req032 recover", value0, 7);
    sendStr("255\r256\r");
    check("max255 value1", value1, 255);
    check("max256 value0", value0, 256);

    sendStr("1x\n5\n");
    check("req033 value", value0, 5);

    // Reset mid-frame discards "45" without a ParseError.
    errs0 = errCount;
    sendStr("45");
    Reset = 1'b1;
    #1;
    check("midreset busy", busy0 | busy1, 0);
    check("midreset value", value0, 0);
    check("midreset pulses", rxAck0 | valueValid0 | parseError0, 0);
    modelReset();
    lastB2b = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    sendStr("6\r");
    check("req034 value", value0, 6);
    check("req034 no err", errCount - errs0, 0);

    // Back-to-back: RxReady never drops, one ack every two cycles.
    acks0 = ackCount;
    sendByte("3", 1'b1);
    sendByte("1", 1'b1);
    sendByte("4", 1'b1);
    sendByte("1", 1'b1);
    sendByte(8'h0D, 1'b0);
    check("req035 acks", ackCount - acks0, 5);
    check("req035 value", value0, 3141);

    // Random byte stream biased toward digits.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      b = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 80) b = 8'h0D;
      else if (r < 90) b = 8'h0A;
      else             b = 8'($urandom_range(8'h3A, 8'h7E));
      sendByte(b, (n != 299) && ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/uart_decimal_parser.md
UART_DECIMAL_PARSER -- requirements
Module: uart_decimal_parser

Interface
REQ-001 Parameter INPUT_BIT_WIDTH, default 16: width of the Value output.
REQ-002 Parameter MAX_VALUE, default 9999: largest value accepted.
REQ-003 Parameter MAX_DIGITS, default 4: largest number of digits accepted per frame.
REQ-004 Port Clk, input, 1: the single clock; all state changes on posedge Clk.
REQ-005 Port Reset, input, 1: asynchronous, active-high reset.
REQ-006 Port RxData, input, 8: received byte from the UART receiver.
REQ-007 Port RxReady, input, 1: RxData holds an unconsumed byte.
REQ-008 Port RxAck, output, 1: one-cycle pulse that consumes the current byte.
REQ-009 Port Value, output, INPUT_BIT_WIDTH: last successfully parsed number.
REQ-010 Port ValueValid, output, 1: one-cycle pulse when Value updates.
REQ-011 Port ParseError, output, 1: one-cycle pulse when a frame is rejected.
REQ-012 Port Busy, output, 1: high while state is not IDLE.

Function
REQ-013 Byte sampling: the block SHALL sample RxData in any cycle where RxReady=1 and RxAck=0, and SHALL drive RxAck=1 in the next cycle only.
REQ-014 No second byte SHALL be sampled in a cycle where RxAck=1, so RxReady still high during the ack cycle is not double-consumed.
REQ-015 Byte classes: digit 0x30-0x39; terminator CR 0x0D or LF 0x0A; every other byte is invalid.
REQ-016 States: IDLE (no digits yet), ACCUM (one or more digits held), DISCARD (rejected frame, waiting for a terminator).
REQ-017 IDLE:
- digit -> acc=digit, count=1, go to ACCUM.
- terminator -> ignored (so CR LF pairs and empty lines produce no output).
- invalid byte -> ParseError, go to DISCARD.
REQ-018 ACCUM, digit: next = acc*10 + digit, computed INPUT_BIT_WIDTH+4 bits wide (no truncation).
- If count = MAX_DIGITS or next > MAX_VALUE: ParseError, go to DISCARD.
- Otherwise acc=next, count+1.
REQ-019 ACCUM:
- terminator -> Value=acc, ValueValid, go to IDLE.
- invalid byte -> ParseError, go to DISCARD.
REQ-020 DISCARD: terminator -> go to IDLE; all other bytes are consumed silently.
REQ-021 Latency: ValueValid and ParseError SHALL be asserted in the same cycle as the RxAck of the byte that caused them.
REQ-022 Value SHALL hold its contents between ValueValid pulses; a rejected frame SHALL NOT alter Value.
REQ-023 ValueValid and ParseError SHALL never be high in the same cycle.
REQ-024 Leading zeros count toward MAX_DIGITS: "0042" is accepted, "00042" is rejected.
REQ-025 Boundary: "9999" is accepted; "10000" is rejected at its 5th digit; with MAX_VALUE=255, "256" is rejected at its 3rd digit.

Reset
REQ-026 On Reset assertion, asynchronously and regardless of state:
- state IDLE;
- acc=0, count=0;
- Value=0;
- RxAck, ValueValid, ParseError and Busy all 0.
REQ-027 Reset mid-frame SHALL discard the partial number with no ParseError; the first byte after deassertion is parsed from IDLE.

Structure
REQ-028 ASCII constants (CR, LF, '0', '9') and the state encoding SHALL live in a shared UART ASCII package/header reused by the matching decimal transmitter.
REQ-029 One sub-module, ascii_digit_classifier (combinational: byte -> is_digit, is_term, digit[3:0]), SHALL be instantiated; everything else stays in uart_decimal_parser.

Verification
REQ-030 Bytes "1","2","3",CR, each presented RxReady for 3 cycles -> exactly 4 RxAck pulses, Value=123, ValueValid once coincident with the CR ack.
REQ-031 "9999",CR,LF -> Value=9999 with one ValueValid; the LF produces no output.
REQ-032 "10000",CR -> ParseError at the 5th digit, no ValueValid, Value unchanged from the prior frame; a following "7",CR -> Value=7.
REQ-033 "1x",LF -> ParseError on 'x'; a following "5",LF -> Value=5.
REQ-034 Reset asserted after "45" mid-frame, then "6",CR -> Value=6, no ParseError during or after the reset.
REQ-035 Back-to-back bytes with RxReady held high continuously -> one RxAck every 2 cycles, no byte sampled twice.
